// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/stop handshake.
// Optional `DIV_ZERO_FAST_EN: short-circuits divide-by-zero and adds o_div_zero.
module seq_divider #(
   parameter int DW = 8,
   parameter int CW = $clog2(DW + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic [DW-1:0] i_dvdnd_val,
   input  logic [DW-1:0] i_dvsr_val,
   output logic [DW-1:0] o_quotient,
   output logic [DW-1:0] o_remainder,
   output logic          o_busy,
   output logic          o_stop
`ifdef DIV_ZERO_FAST_EN
   ,
   output logic          o_div_zero
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t        r_state, w_next;
   logic [DW-1:0] r_quo, r_dvsr, r_rem;
   logic [CW-1:0] r_cnt;
   logic [DW:0]   w_rsh, w_diff;
   logic          w_last;

   // After each restore step R < D, so its top bit is always zero and only DW bits are stored.
   assign w_rsh  = {r_rem, r_quo[DW-1]};
   assign w_diff = w_rsh - {1'b0, r_dvsr};
   assign w_last = (r_cnt == CW'(DW - 1));
   assign o_busy = (r_state != S_IDLE);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (i_start) begin
`ifdef DIV_ZERO_FAST_EN
            w_next = (i_dvsr_val == '0) ? S_DONE : S_CALC;
`else
            w_next = S_CALC;
`endif
         end
         S_CALC: if (w_last) w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_quo       <= '0;
         r_dvsr      <= '0;
         r_rem       <= '0;
         r_cnt       <= '0;
         o_quotient  <= '0;
         o_remainder <= '0;
         o_stop      <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
         o_div_zero  <= 1'b0;
`endif
      end else begin
         o_stop <= 1'b0;
         case (r_state)
            S_IDLE: if (i_start) begin
               r_quo  <= i_dvdnd_val;
               r_dvsr <= i_dvsr_val;
               r_rem  <= '0;
               r_cnt  <= '0;
`ifdef DIV_ZERO_FAST_EN
               o_div_zero <= 1'b0;
`endif
            end
            S_CALC: begin
               r_cnt <= r_cnt + CW'(1);
               if (!w_diff[DW]) begin
                  r_rem <= w_diff[DW-1:0];
                  r_quo <= {r_quo[DW-2:0], 1'b1};
               end else begin
                  r_rem <= w_rsh[DW-1:0];
                  r_quo <= {r_quo[DW-2:0], 1'b0};
               end
            end
            S_DONE: begin
               o_stop <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
               // Fast path never shifted, so Q still holds the dividend.
               if (r_dvsr == '0) begin
                  o_quotient  <= '1;
                  o_remainder <= r_quo;
                  o_div_zero  <= 1'b1;
               end else begin
                  o_quotient  <= r_quo;
                  o_remainder <= r_rem;
               end
`else
               o_quotient  <= r_quo;
               o_remainder <= r_rem;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: table of operations, multi-cycle corner sequences
// and a random quotient/remainder identity sweep.
module tb_seq_divider;
   localparam int DW = 8;
`ifdef DIV_ZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, start;
   logic [DW-1:0] dvd, dvs, q, r;
   logic          busy, stop;
`ifdef DIV_ZERO_FAST_EN
   logic          dz;
`endif

   int checks   = 0;
   int failures = 0;

   seq_divider #(.DW(DW)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .i_dvdnd_val(dvd), .i_dvsr_val(dvs),
      .o_quotient(q), .o_remainder(r), .o_busy(busy), .o_stop(stop)
`ifdef DIV_ZERO_FAST_EN
      , .o_div_zero(dz)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] eq;
      logic [DW-1:0] er;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Pulse start for one cycle, then watch outputs at each falling edge.
   task automatic run_raw(input logic [DW-1:0] a, input logic [DW-1:0] b, input int lat,
                          output logic [DW-1:0] sq, output logic [DW-1:0] sr,
                          output int stop_at, output int stop_cnt, output int busy_cnt,
                          output logic sdz);
      @(negedge clk);
      start = 1'b1; dvd = a; dvs = b;
      @(negedge clk);
      start = 1'b0; dvd = DW'($urandom); dvs = DW'($urandom);
      stop_at = 0; stop_cnt = 0; busy_cnt = 0; sq = '0; sr = '0; sdz = 1'b0;
      for (int n = 1; n <= lat + 2; n++) begin
         if (busy) busy_cnt++;
         if (stop) begin
            stop_cnt++;
            if (stop_at == 0) begin
               stop_at = n; sq = q; sr = r;
`ifdef DIV_ZERO_FAST_EN
               sdz = dz;
`endif
            end
         end
         if (n < lat + 2) @(negedge clk);
      end
   endtask

   task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] eq, input logic [DW-1:0] er, input string tag);
      logic [DW-1:0] sq, sr;
      int stop_at, stop_cnt, busy_cnt, lat;
      logic sdz;
      lat = (FAST && b == '0) ? 2 : DW + 2;
      run_raw(a, b, lat, sq, sr, stop_at, stop_cnt, busy_cnt, sdz);
      chk({tag, " stop_cycle"}, stop_at, lat);
      chk({tag, " stop_pulses"}, stop_cnt, 1);
      chk({tag, " busy_cycles"}, busy_cnt, lat - 1);
      chk({tag, " quotient"}, sq, eq);
      chk({tag, " remainder"}, sr, er);
      chk({tag, " q_held"}, q, eq);
      chk({tag, " r_held"}, r, er);
`ifdef DIV_ZERO_FAST_EN
      chk({tag, " div_zero"}, sdz, (b == '0));
`endif
   endtask

   initial begin
      logic [DW-1:0] sq, sr;
      int stop_at, stop_cnt, busy_cnt, s1, s2, nstop;
      logic sdz;
      logic [DW-1:0] q1, r1, q2, r2;
      logic [15:0] a16, b16, q16, r16;

      vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2};
      vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0};
      vecs[2] = '{8'd5,   8'd10,  8'd0,   8'd5};
      vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0};
      vecs[4] = '{8'd0,   8'd3,   8'd0,   8'd0};
      vecs[5] = '{8'h5A,  8'd0,   8'hFF,  8'h5A};

      rst = 1'b1; start = 1'b0; dvd = '0; dvs = '0;
      repeat (2) @(negedge clk);
      chk("reset quotient", q, 0);
      chk("reset remainder", r, 0);
      chk("reset busy", busy, 0);
      chk("reset stop", stop, 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, $sformatf("vec%0d", i));

      // Asynchronous reset mid-division; outputs held nonzero from the previous result.
      @(negedge clk);
      start = 1'b1; dvd = 8'd100; dvs = 8'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort quotient", q, 0);
      chk("abort remainder", r, 0);
      chk("abort busy", busy, 0);
      chk("abort stop", stop, 0);
      @(negedge clk);
      rst = 1'b0;
      nstop = 0;
      for (int n = 0; n < 14; n++) begin
         @(negedge clk);
         if (stop) nstop++;
      end
      chk("abort no_stop", nstop, 0);
      run_op(8'd100, 8'd7, 8'd14, 8'd2, "after_abort");

      // Start held high through CALC with new operands; only the first IDLE cycle accepts them.
      @(negedge clk);
      start = 1'b1; dvd = 8'd200; dvs = 8'd9;
      @(negedge clk);
      dvd = 8'd50; dvs = 8'd5;
      s1 = 0; s2 = 0; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
      for (int n = 1; n <= 24; n++) begin
         if (stop) begin
            if (s1 == 0) begin s1 = n; q1 = q; r1 = r; end
            else if (s2 == 0) begin s2 = n; q2 = q; r2 = r; end
         end
         if (n == 11) start = 1'b0;
         @(negedge clk);
      end
      chk("b2b first_stop", s1, DW + 2);
      chk("b2b first_q", q1, 22);
      chk("b2b first_r", r1, 2);
      chk("b2b second_stop", s2, 2 * (DW + 2));
      chk("b2b second_q", q2, 10);
      chk("b2b second_r", r2, 0);

      for (int i = 0; i < 1000; i++) begin
         a16 = 16'($urandom_range(255, 0));
         b16 = 16'($urandom_range(255, 1));
         run_raw(a16[7:0], b16[7:0], DW + 2, sq, sr, stop_at, stop_cnt, busy_cnt, sdz);
         q16 = {8'd0, sq}; r16 = {8'd0, sr};
         chk($sformatf("rand%0d identity %0d/%0d", i, a16, b16), q16 * b16 + r16, a16);
         chk($sformatf("rand%0d rem_lt_div", i), (r16 < b16), 1);
         chk($sformatf("rand%0d stop_cycle", i), stop_at, DW + 2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential restoring divider. It produces one quotient bit per clock and is the inverse of the team's shift-add multiplier datapath. It sits beside the multiplier in the arithmetic unit and uses the same start/stop handshake style. The block is built from a control FSM, a dividend/quotient shift register, a divisor register and a (DW+1)-bit partial-remainder subtractor.

Parameters:
DW, 8, width of dividend, divisor, quotient and remainder (unsigned)
CW, $clog2(DW+1), width of the internal bit counter

Ports:
i_clk  input  1  clock, rising-edge
i_rst  input  1  asynchronous, active-high reset
i_start  input  1  request a division; sampled only in IDLE
i_dvdnd_val  input  DW  dividend, captured on accepted start
i_dvsr_val  input  DW  divisor, captured on accepted start
o_quotient  output  DW  quotient, valid from the o_stop cycle and held until the next start
o_remainder  output  DW  remainder, valid and held as for o_quotient
o_busy  output  1  high while in CALC or DONE
o_stop  output  1  one-cycle pulse when the result is valid

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Asserting i_rst at any time forces IDLE.
  - o_quotient=0, o_remainder=0, o_busy=0, o_stop=0; all internal registers cleared.
  - Reset mid-operation aborts the division with no o_stop pulse.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - i_start=1 at rising edge k: capture dividend into Q register, divisor into D register; clear partial remainder R (DW+1 bits) and counter; go to CALC.
  - i_start=0: stay in IDLE; outputs hold their previous values.
- CALC, once per edge:
  - {R,Q} shifted left by 1.
  - T = R_shifted - {1'b0,D}.
  - If T is non-negative (MSB=0): R=T and Q[0]=1. Otherwise R is kept and Q[0]=0.
  - counter increments; after DW iterations (edge k+DW), go to DONE.
- DONE:
  - o_quotient<=Q, o_remainder<=R[DW-1:0].
  - o_stop=1 for exactly this one cycle; next edge returns to IDLE.
  - The result registers update on entry to DONE and hold afterwards.
- Latency: i_start accepted at edge k → o_stop high in the cycle after edge k+DW+1, i.e. DW+2 cycles from start to stop.
- i_start while o_busy=1: ignored; the in-flight operation is unaffected and the operands are not re-captured.
- i_start high in the cycle after DONE (back in IDLE): accepted normally, giving back-to-back operation with one IDLE cycle minimum.
- Arithmetic is unsigned only.
- Divisor = 0: the algorithm runs unchanged. The natural result is quotient all-ones and remainder = dividend; this is the defined result.
- Dividend < divisor: quotient 0, remainder = dividend.
- Operand inputs are don't-care except in the accepting cycle.

Optional Feature:
Macro DIV_ZERO_FAST_EN.
- Defined:
  - Adds output port o_div_zero (1 bit, reset 0).
  - If the captured divisor is 0, the FSM skips CALC and goes IDLE→DONE in one edge.
  - Result: o_quotient={DW{1'b1}}, o_remainder=dividend; o_div_zero=1 alongside o_stop.
  - o_div_zero clears on the next accepted start.
  - Latency for divide-by-zero becomes 2 cycles.
- Not defined:
  - No o_div_zero port.
  - Divide-by-zero takes the full DW iterations and produces the same quotient/remainder values.

Test Plan:
- DW=8, dividend=100, divisor=7, pulse start → o_stop once, 10 cycles after start; quotient=14, remainder=2; o_busy high for 9 cycles.
- Boundary values, run in sequence:
  - 255/1 → q=255, r=0
  - 5/10 → q=0, r=5
  - 255/255 → q=1, r=0
  - 0/3 → q=0, r=0
- Divisor 0, dividend 0x5A → q=0xFF, r=0x5A.
  - With DIV_ZERO_FAST_EN: o_stop 2 cycles after start and o_div_zero=1.
  - Without it: o_stop 10 cycles after start.
- Start 200/9, then hold i_start high with new operands 50/5 throughout CALC:
  - first result q=22, r=2, unaffected by the new operands;
  - second start accepted in the first IDLE cycle → q=10, r=0.
- Start 100/7, assert i_rst at cycle 4 → all outputs 0 immediately (asynchronous), no o_stop pulse. After release, 100/7 completes with q=14, r=2.
- Random sweep: 1000 random operand pairs with divisor≠0 → q*divisor+r==dividend and r<divisor for every pair.
